// File: rtl/fifo_line_buf.sv
// Single-clock line-buffer FIFO (registered read, one-cycle latency) for the 3x3 window generator.
// Define FIFO_LINE_BUF_WATER_LEVEL_EN to add wr_water_level/rd_water_level occupancy outputs.
module fifo_line_buf #(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDR_WIDTH       = 12,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  wr_full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty,
    output logic                  almost_empty
`ifdef FIFO_LINE_BUF_WATER_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   wr_water_level,
    output logic [ADDR_WIDTH:0]   rd_water_level
`endif
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] DEPTH_CNT = PW'(1) << ADDR_WIDTH;
    localparam logic [PW-1:0] AF_CNT    = PW'(ALMOST_FULL_NUM);
    localparam logic [PW-1:0] AE_CNT    = PW'(ALMOST_EMPTY_NUM);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW-1:0]         wr_ptr_nxt, rd_ptr_nxt, cnt_nxt;
    logic                  wr_accept, rd_accept;

    // Handshake: wr_en is a write valid and !wr_full its ready; rd_en is a read valid and
    // !rd_empty its ready. A transfer happens only on a rising edge where both are high.
    assign wr_accept  = wr_en && !wr_full;
    assign rd_accept  = rd_en && !rd_empty;
    assign wr_ptr_nxt = wr_accept ? wr_ptr + PTR_ONE : wr_ptr;
    assign rd_ptr_nxt = rd_accept ? rd_ptr + PTR_ONE : rd_ptr;
    assign cnt_nxt    = wr_ptr_nxt - rd_ptr_nxt;

    // Flags come from the next-state count so they are registered yet exact.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            rd_empty     <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            wr_full      <= (cnt_nxt == DEPTH_CNT);
            almost_full  <= (cnt_nxt >= AF_CNT);
            rd_empty     <= (cnt_nxt == '0);
            almost_empty <= (cnt_nxt <= AE_CNT);
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            rd_data <= '0;
        end else if (rd_accept) begin
            rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

`ifdef FIFO_LINE_BUF_WATER_LEVEL_EN
    logic [PW-1:0] count_q;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            count_q <= '0;
        end else begin
            count_q <= cnt_nxt;
        end
    end

    assign wr_water_level = count_q;
    assign rd_water_level = count_q;
`endif

endmodule

// File: tb/tb_fifo_line_buf.sv
// Randomized scoreboard bench for fifo_line_buf: a queue-based model predicts data and flags,
// a separate monitor pops expected read data one cycle after each accepted read.
module tb_fifo_line_buf;

    localparam int DW    = 8;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;
    localparam int AF    = 1020;
    localparam int AE    = 4;

    logic          clk = 1'b0;
    logic          tb_rst = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          wr_full, almost_full, rd_empty, almost_empty;
    logic [DW-1:0] rd_data;
`ifdef FIFO_LINE_BUF_WATER_LEVEL_EN
    logic [AW:0]   wr_water_level, rd_water_level;
`endif

    fifo_line_buf #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)
    ) dut (
        .clk(clk), .tb_rst(tb_rst),
        .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full), .almost_full(almost_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .almost_empty(almost_empty)
`ifdef FIFO_LINE_BUF_WATER_LEVEL_EN
        , .wr_water_level(wr_water_level), .rd_water_level(rd_water_level)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: contents as a plain queue; expected read data for the monitor.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_valid_now = 1'b0;
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check_flags();
        int n;
        n = model_q.size();
        chk("rd_empty", int'(rd_empty), int'(n == 0));
        chk("wr_full", int'(wr_full), int'(n == DEPTH));
        chk("almost_full", int'(almost_full), int'(n >= AF));
        chk("almost_empty", int'(almost_empty), int'(n <= AE));
`ifdef FIFO_LINE_BUF_WATER_LEVEL_EN
        chk("wr_water_level", int'(wr_water_level), n);
        chk("rd_water_level", int'(rd_water_level), n);
`endif
    endtask

    // One clock: called at a negedge, drives inputs, updates the model, checks flags at next negedge.
    task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re);
        logic rd_ok, wr_ok;
        rd_ok = re && (model_q.size() > 0);
        wr_ok = we && (model_q.size() < DEPTH);
        if (rd_ok) exp_q.push_back(model_q.pop_front());
        if (wr_ok) model_q.push_back(wd);
        wr_en = we;
        wr_data = wd;
        rd_en = re;
        exp_valid_now = rd_ok;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        exp_valid_now = 1'b0;
        check_flags();
    endtask

    task automatic pulse_reset();
        cycle(1'b0, '0, 1'b0);
        tb_rst = 1'b1;
        #1;
        chk("rst_rd_empty", int'(rd_empty), 1);
        chk("rst_almost_empty", int'(almost_empty), 1);
        chk("rst_wr_full", int'(wr_full), 0);
        chk("rst_almost_full", int'(almost_full), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        model_q.delete();
        exp_q.delete();
        @(negedge clk);
        tb_rst = 1'b0;
    endtask

    // Monitor: pops one expected word per accepted read, otherwise rd_data must hold.
    initial begin
        logic          v, r;
        logic [DW-1:0] hold_val;
        logic [DW-1:0] e;
        hold_val = '0;
        forever begin
            @(posedge clk);
            v = exp_valid_now;
            r = tb_rst;
            @(negedge clk);
            if (r || tb_rst) begin
                hold_val = '0;
            end else if (v) begin
                if (exp_q.size() == 0) begin
                    chk("rd_data_queue_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", int'(rd_data), int'(e));
                    hold_val = e;
                end
            end else begin
                chk("rd_data_hold", int'(rd_data), int'(hold_val));
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        repeat (20) @(negedge clk);
        tb_rst = 1'b0;
        chk("reset_rd_empty", int'(rd_empty), 1);
        chk("reset_almost_empty", int'(almost_empty), 1);
        chk("reset_wr_full", int'(wr_full), 0);
        chk("reset_almost_full", int'(almost_full), 0);
        chk("reset_rd_data", int'(rd_data), 0);

        // Fill past full with decrementing data; the last write must be dropped.
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, DW'(8'hFF - i), 1'b0);
        chk("fill_count", model_q.size(), DEPTH);
        // Drain one past empty; the extra read must leave rd_data at 0x00.
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Simultaneous read/write at occupancy 1.
        cycle(1'b1, DW'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, DW'($urandom_range(0, 255)), 1'b1);
        chk("simul_count", model_q.size(), 1);
        cycle(1'b0, '0, 1'b1);

        // From empty, a same-cycle read is rejected and only the write lands.
        cycle(1'b1, 8'h5A, 1'b1);
        chk("boundary_count", model_q.size(), 1);
        cycle(1'b0, '0, 1'b1);

        // Reset in the middle of a partly filled FIFO.
        for (int i = 0; i < 100; i++) cycle(1'b1, DW'($urandom_range(0, 255)), 1'b0);
        pulse_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);

        // Random traffic with read-heavy and write-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            d = DW'($urandom_range(0, 255));
            if (i < 1500) cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) == 0);
            else cycle($urandom_range(0, 3) == 0, d, $urandom_range(0, 3) != 0);
        end
        while (model_q.size() > 0) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
